// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter sharing one TileLink-UL style data-memory port between LSU and DMA.
// Optional response timeout enabled with DMEM_ARB_TIMEOUT_EN.
module dmem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_a_valid_i,
  output logic                  m0_a_ready_o,
  input  logic [ADDR_WIDTH-1:0] m0_a_address_i,
  input  logic [2:0]            m0_a_opcode_i,
  input  logic [DATA_WIDTH-1:0] m0_a_data_i,
  input  logic [1:0]            m0_a_size_i,
  input  logic [1:0]            m0_a_mask_i,
  output logic                  m0_d_valid_o,
  output logic [2:0]            m0_d_opcode_o,
  output logic [1:0]            m0_d_size_o,
  output logic [DATA_WIDTH-1:0] m0_d_data_o,
`ifdef DMEM_ARB_TIMEOUT_EN
  output logic                  m0_d_error_o,
  output logic                  m1_d_error_o,
`endif
  input  logic                  m1_a_valid_i,
  output logic                  m1_a_ready_o,
  input  logic [ADDR_WIDTH-1:0] m1_a_address_i,
  input  logic [2:0]            m1_a_opcode_i,
  input  logic [DATA_WIDTH-1:0] m1_a_data_i,
  input  logic [1:0]            m1_a_size_i,
  input  logic [1:0]            m1_a_mask_i,
  output logic                  m1_d_valid_o,
  output logic [2:0]            m1_d_opcode_o,
  output logic [1:0]            m1_d_size_o,
  output logic [DATA_WIDTH-1:0] m1_d_data_o,
  output logic                  s_a_valid_o,
  output logic [ADDR_WIDTH-1:0] s_a_address_o,
  output logic [2:0]            s_a_opcode_o,
  output logic [DATA_WIDTH-1:0] s_a_data_o,
  output logic [1:0]            s_a_size_o,
  output logic [1:0]            s_a_mask_o,
  input  logic                  s_d_valid_i,
  input  logic [2:0]            s_d_opcode_i,
  input  logic [1:0]            s_d_size_i,
  input  logic [DATA_WIDTH-1:0] s_d_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic grant_q, grant_d;
  logic last_q, last_d;
  logic sav_q, sav_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0] aop_q, aop_d;
  logic [DATA_WIDTH-1:0] adata_q, adata_d;
  logic [1:0] asize_q, asize_d;
  logic [1:0] amask_q, amask_d;
  logic [2:0] dop_q, dop_d;
  logic [1:0] dsize_q, dsize_d;
  logic [DATA_WIDTH-1:0] ddata_q, ddata_d;
  logic dv0_q, dv0_d;
  logic dv1_q, dv1_d;
`ifdef DMEM_ARB_TIMEOUT_EN
  localparam logic [3:0] WAIT_LIM = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] wait_q, wait_d;
  logic derr_q, derr_d;
`endif

  logic win0, win1;

  // On contention the requester that did not win last time gets the bus.
  assign win0 = (state_q == IDLE) && m0_a_valid_i
              && (!m1_a_valid_i || last_q);
  assign win1 = (state_q == IDLE) && m1_a_valid_i
              && (!m0_a_valid_i || !last_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    sav_d   = sav_q;
    addr_d  = addr_q;
    aop_d   = aop_q;
    adata_d = adata_q;
    asize_d = asize_q;
    amask_d = amask_q;
    dop_d   = dop_q;
    dsize_d = dsize_q;
    ddata_d = ddata_q;
    dv0_d   = 1'b0;
    dv1_d   = 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
    wait_d  = wait_q;
    derr_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win0 || win1) begin
          grant_d = win1;
          addr_d  = win1 ? m1_a_address_i : m0_a_address_i;
          aop_d   = win1 ? m1_a_opcode_i  : m0_a_opcode_i;
          adata_d = win1 ? m1_a_data_i    : m0_a_data_i;
          asize_d = win1 ? m1_a_size_i    : m0_a_size_i;
          amask_d = win1 ? m1_a_mask_i    : m0_a_mask_i;
          sav_d   = 1'b1;
          state_d = ISSUE;
`ifdef DMEM_ARB_TIMEOUT_EN
          wait_d  = 4'd0;
`endif
        end
      end
      ISSUE: begin
        if (s_d_valid_i) begin
          dop_d   = s_d_opcode_i;
          dsize_d = s_d_size_i;
          ddata_d = s_d_data_i;
          sav_d   = 1'b0;
          dv0_d   = !grant_q;
          dv1_d   = grant_q;
          state_d = RESP;
        end
`ifdef DMEM_ARB_TIMEOUT_EN
        else if (wait_q == WAIT_LIM) begin
          dop_d   = (aop_q == 3'b100) ? 3'b001 : 3'b000;
          dsize_d = asize_q;
          ddata_d = DATA_WIDTH'(32'hDEAD_BEEF);
          derr_d  = 1'b1;
          sav_d   = 1'b0;
          dv0_d   = !grant_q;
          dv1_d   = grant_q;
          state_d = RESP;
        end else begin
          wait_d = wait_q + 4'd1;
        end
`endif
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      sav_q   <= 1'b0;
      addr_q  <= '0;
      aop_q   <= '0;
      adata_q <= '0;
      asize_q <= '0;
      amask_q <= '0;
      dop_q   <= '0;
      dsize_q <= '0;
      ddata_q <= '0;
      dv0_q   <= 1'b0;
      dv1_q   <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      wait_q  <= '0;
      derr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      sav_q   <= sav_d;
      addr_q  <= addr_d;
      aop_q   <= aop_d;
      adata_q <= adata_d;
      asize_q <= asize_d;
      amask_q <= amask_d;
      dop_q   <= dop_d;
      dsize_q <= dsize_d;
      ddata_q <= ddata_d;
      dv0_q   <= dv0_d;
      dv1_q   <= dv1_d;
`ifdef DMEM_ARB_TIMEOUT_EN
      wait_q  <= wait_d;
      derr_q  <= derr_d;
`endif
    end
  end

  assign m0_a_ready_o  = win0;
  assign m1_a_ready_o  = win1;
  assign s_a_valid_o   = sav_q;
  assign s_a_address_o = addr_q;
  assign s_a_opcode_o  = aop_q;
  assign s_a_data_o    = adata_q;
  assign s_a_size_o    = asize_q;
  assign s_a_mask_o    = amask_q;
  assign m0_d_valid_o  = dv0_q;
  assign m1_d_valid_o  = dv1_q;
  assign m0_d_opcode_o = dop_q;
  assign m1_d_opcode_o = dop_q;
  assign m0_d_size_o   = dsize_q;
  assign m1_d_size_o   = dsize_q;
  assign m0_d_data_o   = ddata_q;
  assign m1_d_data_o   = ddata_q;
`ifdef DMEM_ARB_TIMEOUT_EN
  assign m0_d_error_o  = derr_q & dv0_q;
  assign m1_d_error_o  = derr_q & dv1_q;
`endif

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter: directed requests, queued expected responses.
module tb_dmem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_a_valid_i, m1_a_valid_i;
  logic        m0_a_ready_o, m1_a_ready_o;
  logic [11:0] m0_a_address_i, m1_a_address_i;
  logic [2:0]  m0_a_opcode_i, m1_a_opcode_i;
  logic [31:0] m0_a_data_i, m1_a_data_i;
  logic [1:0]  m0_a_size_i, m1_a_size_i;
  logic [1:0]  m0_a_mask_i, m1_a_mask_i;
  logic        m0_d_valid_o, m1_d_valid_o;
  logic [2:0]  m0_d_opcode_o, m1_d_opcode_o;
  logic [1:0]  m0_d_size_o, m1_d_size_o;
  logic [31:0] m0_d_data_o, m1_d_data_o;
  logic        s_a_valid_o;
  logic [11:0] s_a_address_o;
  logic [2:0]  s_a_opcode_o;
  logic [31:0] s_a_data_o;
  logic [1:0]  s_a_size_o, s_a_mask_o;
  logic        s_d_valid_i;
  logic [2:0]  s_d_opcode_i;
  logic [1:0]  s_d_size_i;
  logic [31:0] s_d_data_i;
`ifdef DMEM_ARB_TIMEOUT_EN
  logic        m0_d_error_o, m1_d_error_o;
`endif

  dmem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_a_valid_i(m0_a_valid_i), .m0_a_ready_o(m0_a_ready_o),
    .m0_a_address_i(m0_a_address_i), .m0_a_opcode_i(m0_a_opcode_i),
    .m0_a_data_i(m0_a_data_i), .m0_a_size_i(m0_a_size_i),
    .m0_a_mask_i(m0_a_mask_i),
    .m0_d_valid_o(m0_d_valid_o), .m0_d_opcode_o(m0_d_opcode_o),
    .m0_d_size_o(m0_d_size_o), .m0_d_data_o(m0_d_data_o),
`ifdef DMEM_ARB_TIMEOUT_EN
    .m0_d_error_o(m0_d_error_o), .m1_d_error_o(m1_d_error_o),
`endif
    .m1_a_valid_i(m1_a_valid_i), .m1_a_ready_o(m1_a_ready_o),
    .m1_a_address_i(m1_a_address_i), .m1_a_opcode_i(m1_a_opcode_i),
    .m1_a_data_i(m1_a_data_i), .m1_a_size_i(m1_a_size_i),
    .m1_a_mask_i(m1_a_mask_i),
    .m1_d_valid_o(m1_d_valid_o), .m1_d_opcode_o(m1_d_opcode_o),
    .m1_d_size_o(m1_d_size_o), .m1_d_data_o(m1_d_data_o),
    .s_a_valid_o(s_a_valid_o), .s_a_address_o(s_a_address_o),
    .s_a_opcode_o(s_a_opcode_o), .s_a_data_o(s_a_data_o),
    .s_a_size_o(s_a_size_o), .s_a_mask_o(s_a_mask_o),
    .s_d_valid_i(s_d_valid_i), .s_d_opcode_i(s_d_opcode_i),
    .s_d_size_i(s_d_size_i), .s_d_data_i(s_d_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m;
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_m(input bit m, input logic v,
                         input logic [11:0] a, input logic [2:0] op,
                         input logic [31:0] d, input logic [1:0] sz,
                         input logic [1:0] mk);
    if (!m) begin
      m0_a_valid_i = v; m0_a_address_i = a; m0_a_opcode_i = op;
      m0_a_data_i = d; m0_a_size_i = sz; m0_a_mask_i = mk;
    end else begin
      m1_a_valid_i = v; m1_a_address_i = a; m1_a_opcode_i = op;
      m1_a_data_i = d; m1_a_size_i = sz; m1_a_mask_i = mk;
    end
  endtask

  // Full transaction; delay = ISSUE cycles before the slave answers.
  task automatic do_req(input bit m, input logic [2:0] op,
                        input logic [11:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic [1:0] mk,
                        input int delay, input bit respond,
                        input logic [31:0] rd);
    exp_t e;
    logic rdy;
    int   n;
    drive_m(m, 1'b1, a, op, wd, sz, mk);
    #1;
    n = 0;
    rdy = m ? m1_a_ready_o : m0_a_ready_o;
    while (!rdy && n < 10) begin
      @(negedge clk); #1; n++;
      rdy = m ? m1_a_ready_o : m0_a_ready_o;
    end
    chk("accept", {63'd0, rdy}, 64'd1);
    if (!rdy) begin
      drive_m(m, 1'b0, a, op, wd, sz, mk);
      return;
    end
    chk("loser_ready", {63'd0, m ? m0_a_ready_o : m1_a_ready_o}, 64'd0);
    @(negedge clk);
    drive_m(m, 1'b0, a, op, wd, sz, mk);
    e.m = m; e.sz = sz;
    for (int k = 1; k <= delay; k++) begin
      chk("issue_valid", {63'd0, s_a_valid_o}, 64'd1);
      chk("s_a_addr", {52'd0, s_a_address_o}, {52'd0, a});
      chk("s_a_op", {61'd0, s_a_opcode_o}, {61'd0, op});
      chk("s_a_data", {32'd0, s_a_data_o}, {32'd0, wd});
      chk("s_a_size_mask", {60'd0, s_a_size_o, s_a_mask_o},
          {60'd0, sz, mk});
      if (!respond && k == delay) begin
        e.op = (op == 3'b100) ? 3'b001 : 3'b000;
        e.data = 32'hDEAD_BEEF; e.err = 1'b1;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    if (respond) begin
      chk("issue_valid", {63'd0, s_a_valid_o}, 64'd1);
      chk("s_a_addr", {52'd0, s_a_address_o}, {52'd0, a});
      s_d_valid_i  = 1'b1;
      s_d_opcode_i = (op == 3'b100) ? 3'b001 : 3'b000;
      s_d_size_i   = sz;
      s_d_data_i   = rd;
      e.op = s_d_opcode_i; e.data = rd; e.err = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      s_d_valid_i = 1'b0;
    end
    chk("resp_d_valid", {63'd0, m ? m1_d_valid_o : m0_d_valid_o}, 64'd1);
    chk("resp_s_a_low", {63'd0, s_a_valid_o}, 64'd0);
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever a response pulse appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (m0_d_valid_o || m1_d_valid_o) begin
        if (m0_d_valid_o && m1_d_valid_o) begin
          nchk++; nerr++;
          $display("FAIL both_d_valid: both masters pulsed at %0t", $time);
        end else if (sb.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_d: m0=%0b m1=%0b none expected at %0t",
                   m0_d_valid_o, m1_d_valid_o, $time);
        end else begin
          e = sb.pop_front();
          chk("d_master", {63'd0, m1_d_valid_o}, {63'd0, e.m});
          chk("d_opcode", {61'd0, e.m ? m1_d_opcode_o : m0_d_opcode_o},
              {61'd0, e.op});
          chk("d_size", {62'd0, e.m ? m1_d_size_o : m0_d_size_o},
              {62'd0, e.sz});
          chk("d_data", {32'd0, e.m ? m1_d_data_o : m0_d_data_o},
              {32'd0, e.data});
`ifdef DMEM_ARB_TIMEOUT_EN
          chk("d_error", {63'd0, e.m ? m1_d_error_o : m0_d_error_o},
              {63'd0, e.err});
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   w;
    logic r0, r1;
    rst = 1'b1;
    drive_m(1'b0, 1'b0, 12'h0, 3'b0, 32'h0, 2'b0, 2'b0);
    drive_m(1'b1, 1'b0, 12'h0, 3'b0, 32'h0, 2'b0, 2'b0);
    s_d_valid_i = 1'b0; s_d_opcode_i = 3'b0;
    s_d_size_i = 2'b0; s_d_data_i = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_s_a_valid", {63'd0, s_a_valid_o}, 64'd0);
    chk("rst_d_valid", {62'd0, m0_d_valid_o, m1_d_valid_o}, 64'd0);
    chk("rst_s_a_addr", {52'd0, s_a_address_o}, 64'd0);
    chk("rst_d_data", {32'd0, m0_d_data_o}, 64'd0);
    @(negedge clk);

    do_req(1'b0, 3'b000, 12'h010, 32'h1234_5678, 2'd2, 2'b11, 0, 1'b1,
           32'h0);
    do_req(1'b1, 3'b100, 12'h020, 32'h0, 2'd2, 2'b11, 3, 1'b1,
           32'hCAFE_F00D);

    drive_m(1'b0, 1'b1, 12'h100, 3'b000, 32'hAAAA_0000, 2'd2, 2'b11);
    drive_m(1'b1, 1'b1, 12'h200, 3'b100, 32'h0, 2'd1, 2'b01);
    w = 1'b0;
    for (int t = 0; t < 4; t++) begin
      #1;
      r0 = m0_a_ready_o; r1 = m1_a_ready_o;
      chk("rr_winner", {62'd0, r1, r0}, w ? 64'd2 : 64'd1);
      @(negedge clk);
      chk("rr_ready_pulse", {62'd0, m1_a_ready_o, m0_a_ready_o}, 64'd0);
      chk("rr_addr", {52'd0, s_a_address_o}, w ? 64'h200 : 64'h100);
      s_d_valid_i  = 1'b1;
      s_d_opcode_i = w ? 3'b001 : 3'b000;
      s_d_size_i   = w ? 2'd1 : 2'd2;
      s_d_data_i   = 32'h1000 + t;
      e.m = w; e.op = s_d_opcode_i; e.sz = s_d_size_i;
      e.data = s_d_data_i; e.err = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      s_d_valid_i = 1'b0;
      chk("rr_resp_ready", {62'd0, m1_a_ready_o, m0_a_ready_o}, 64'd0);
      if (t == 3) begin
        m0_a_valid_i = 1'b0;
        m1_a_valid_i = 1'b0;
      end
      @(negedge clk);
      w = ~w;
    end

    drive_m(1'b1, 1'b1, 12'h030, 3'b100, 32'h0, 2'd2, 2'b11);
    #1;
    chk("mid_rst_accept", {63'd0, m1_a_ready_o}, 64'd1);
    @(negedge clk);
    m1_a_valid_i = 1'b0;
    chk("mid_rst_issue", {63'd0, s_a_valid_o}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_s_a", {63'd0, s_a_valid_o}, 64'd0);
    chk("mid_rst_d", {63'd0, m1_d_valid_o}, 64'd0);
    @(negedge clk);
    chk("mid_rst_d2", {63'd0, m1_d_valid_o}, 64'd0);
    do_req(1'b1, 3'b100, 12'h030, 32'h0, 2'd2, 2'b11, 1, 1'b1,
           32'h0BAD_F00D);

    s_d_valid_i = 1'b1; s_d_opcode_i = 3'b001; s_d_data_i = 32'h5555_5555;
    @(negedge clk);
    s_d_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("spurious_s_a", {63'd0, s_a_valid_o}, 64'd0);
    do_req(1'b0, 3'b100, 12'h044, 32'h0, 2'd1, 2'b01, 0, 1'b1,
           32'h7777_8888);

`ifdef DMEM_ARB_TIMEOUT_EN
    do_req(1'b0, 3'b100, 12'h050, 32'h0, 2'd2, 2'b11, 15, 1'b0, 32'h0);
    do_req(1'b0, 3'b100, 12'h054, 32'h0, 2'd2, 2'b11, 14, 1'b1,
           32'h1357_9BDF);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Shares the single data-memory bus port (A/D channel, TileLink-UL style) between two requesters: m0 = core load/store unit, m1 = DMA/debug port.
- Round-robin arbitration with one outstanding transaction at a time.
- Registers the winning request, holds it on the downstream A channel until the slave responds, then routes the registered response back to the granted requester.
- Sits between the core/DMA and the data-memory adapter.

Parameters:
- ADDR_WIDTH, 12, byte address width on every A channel.
- DATA_WIDTH, 32, data width on A and D channels.
- TIMEOUT_CYCLES, 15, maximum ISSUE-state wait before abort. Used only with DMEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- mN_a_valid_i  in  1  request valid, N=0,1; held until accepted.
- mN_a_ready_o  out  1  one-cycle accept pulse.
- mN_a_address_i  in  ADDR_WIDTH  request address.
- mN_a_opcode_i  in  3  000 = PutFullData (write), 100 = Get (read).
- mN_a_data_i  in  DATA_WIDTH  write data.
- mN_a_size_i  in  2  log2 bytes.
- mN_a_mask_i  in  2  lane mask.
- mN_d_valid_o  out  1  one-cycle response pulse.
- mN_d_opcode_o  out  3  000 = AccessAck, 001 = AccessAckData.
- mN_d_size_o  out  2  response size.
- mN_d_data_o  out  DATA_WIDTH  read data.
- s_a_valid_o  out  1  downstream request valid.
- s_a_address_o  out  ADDR_WIDTH  downstream address.
- s_a_opcode_o  out  3  downstream opcode.
- s_a_data_o  out  DATA_WIDTH  downstream write data.
- s_a_size_o  out  2  downstream size.
- s_a_mask_o  out  2  downstream mask.
- s_d_valid_i  in  1  downstream response valid.
- s_d_opcode_i  in  3  downstream response opcode.
- s_d_size_i  in  2  downstream response size.
- s_d_data_i  in  DATA_WIDTH  downstream read data.

Behaviour:
- Single clock clk; rst is synchronous and active-high. While rst is high at a rising edge:
  - state returns to IDLE;
  - all outputs, s_a_* registers, response registers, grant = 0 and last_grant = 1 (so m0 wins first) are cleared to 0.
- Reset mid-transaction aborts it silently: no d_valid is issued and the requester must re-issue.
- FSM IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - s_a_valid_o = 0.
  - If exactly one mN_a_valid_i is high, grant it.
  - If both are high, grant the requester != last_grant.
  - In the grant cycle: mN_a_ready_o = 1 (combinational, winner only); latch the winner's address/opcode/data/size/mask into the s_a_* registers and grant into a register; go to ISSUE.
  - The loser is held off with ready = 0.
- ISSUE:
  - s_a_valid_o = 1; s_a_* are stable.
  - On s_d_valid_i = 1: capture s_d_opcode_i, s_d_size_i and s_d_data_i; go to RESP.
  - s_d_valid_i asserted in IDLE or RESP is ignored.
- RESP:
  - s_a_valid_o = 0.
  - Granted mN_d_valid_o = 1 for exactly one cycle with the captured fields; the other master's d_valid stays 0.
  - last_grant <= grant; go to IDLE.
- mN_d_opcode/size/data hold their last captured value. They are only meaningful while d_valid is high.
- Latency, with a combinational slave response:
  - accept at T;
  - s_a_valid_o high at T+1;
  - mN_d_valid_o at T+2;
  - next accept at the earliest T+3.
- Throughput is 1 transaction per 3 cycles minimum.
- No ready on the D channel: requesters must sink the d_valid pulse.
- Opcodes pass through unmodified; the arbiter does not decode them.

Optional Feature:
- Macro: DMEM_ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter clears on entry to ISSUE and increments each ISSUE cycle without s_d_valid_i.
  - When it reaches TIMEOUT_CYCLES, go to RESP with opcode = s_a_opcode_o==100 ? 001 : 000, size = s_a_size_o and data = 32'hDEAD_BEEF.
  - Add output mN_d_error_o, out, 1: high with d_valid only on a timeout response.
  - If s_d_valid_i arrives in the same cycle the counter hits the limit, the real response wins and d_error = 0.
- Undefined: no counter, no d_error ports, and ISSUE waits indefinitely.

Test Plan:
- After reset, m0 write to 0x010 with data 0x12345678; slave acks with d_valid/opcode 000 the same cycle -> m0_a_ready at T, s_a_valid at T+1, m0_d_valid=1 with opcode 000 at T+2, m1_d_valid stays 0.
- m1 read from 0x020; slave returns 0xCAFEF00D with opcode 001 after 3 ISSUE cycles -> s_a_* stable for all 3 cycles; m1_d_data=0xCAFEF00D, m1_d_opcode=001, one pulse.
- m0 and m1 both valid continuously for 4 transactions -> grants m0, m1, m0, m1; each ready is one cycle long and responses are routed to the matching master.
- rst asserted during ISSUE of an m1 read -> next cycle state IDLE, s_a_valid_o=0, no m1_d_valid; a subsequent m1 request is accepted and completes normally.
- Spurious s_d_valid_i=1 while IDLE with no requests -> no d_valid on either master; the next m0 request completes normally.
- (DMEM_ARB_TIMEOUT_EN) m0 read and the slave never responds -> after 15 ISSUE cycles m0_d_valid=1, m0_d_error=1, opcode 001, data 0xDEADBEEF. A response in cycle 15 yields d_error=0 with the real data.
